// File: rtl/ft_rd_engine.sv
// ft_rd_engine: FT232H synchronous-FIFO (FT245-sync) burst read engine.
// Serialises a 6-byte read command onto the FT232H bus, turns the bus around,
// collects the response bytes and packs them into 64-bit beats.
// Ports:
//   req_*   : burst request (address, beats-1), accepted only in IDLE
//   resp_*  : 64-bit beat stream, single holding register, valid/ready
//   adbus_* : FT232H data bus (tri-state resolved outside)
//   txe_n/rxf_n/wr_n/rd_n/oe_n/siwu_n : FT232H FIFO control pins
module ft_rd_engine #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LEN_W   = 3,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_data,
  output logic              resp_last,
  output logic              resp_err,
  input  logic [7:0]        adbus_i,
  output logic [7:0]        adbus_o,
  output logic              adbus_oe,
  input  logic              txe_n,
  input  logic              rxf_n,
  output logic              wr_n,
  output logic              rd_n,
  output logic              oe_n,
  output logic              siwu_n
);

  localparam int unsigned TMO_W  = 16;
  localparam int unsigned IDX_W  = 3;
  localparam logic [7:0]  CMD_RD = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_TURN, S_RD, S_ABORT, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [7:0][7:0]    lane_q, lane_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_last_q, resp_last_d;
  logic               resp_err_q, resp_err_d;
  logic [63:0]        resp_data_q, resp_data_d;
  logic               stall_c;
  logic               capture_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      tmo_q        <= '0;
      lane_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      idx_q        <= idx_d;
      byte_cnt_q   <= byte_cnt_d;
      tmo_q        <= tmo_d;
      lane_q       <= lane_d;
      resp_valid_q <= resp_valid_d;
      resp_last_q  <= resp_last_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Next-state, datapath and pin control
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    idx_d        = idx_q;
    byte_cnt_d   = byte_cnt_q;
    tmo_d        = tmo_q;
    lane_d       = lane_q;
    resp_valid_d = resp_valid_q;
    resp_last_d  = resp_last_q;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    req_ready    = 1'b0;
    adbus_o      = 8'h00;
    adbus_oe     = 1'b0;
    wr_n         = 1'b1;
    rd_n         = 1'b1;
    oe_n         = 1'b1;
    stall_c      = 1'b0;
    capture_c    = 1'b0;

    // Handshake drains the holding register; a same-cycle load below overrides
    if (resp_valid_q && resp_ready) resp_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d     = 32'(req_addr);
          len_d      = req_len;
          idx_d      = '0;
          byte_cnt_d = '0;
          beat_cnt_d = '0;
          tmo_d      = '0;
          state_d    = S_CMD;
        end
      end
      S_CMD: begin
        adbus_oe = 1'b1;
        wr_n     = txe_n;
        case (idx_q)
          3'd0:    adbus_o = CMD_RD;
          3'd1:    adbus_o = 8'(len_q);
          3'd2:    adbus_o = addr_q[7:0];
          3'd3:    adbus_o = addr_q[15:8];
          3'd4:    adbus_o = addr_q[23:16];
          3'd5:    adbus_o = addr_q[31:24];
          default: adbus_o = 8'h00;
        endcase
        if (!txe_n) begin
          if (idx_q == 3'd5) state_d = S_TURN;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_TURN: begin
        oe_n    = 1'b0;
        tmo_d   = '0;
        state_d = S_RD;
      end
      S_RD: begin
        oe_n = 1'b0;
        // Never take byte 7 of the next beat while the previous beat is held
        stall_c   = (byte_cnt_q == 3'd7) && resp_valid_q && !resp_ready;
        rd_n      = rxf_n | stall_c;
        capture_c = !(rxf_n | stall_c);
        if (capture_c) begin
          lane_d[byte_cnt_q] = adbus_i;
          byte_cnt_d         = byte_cnt_q + 3'd1;
          tmo_d              = '0;
          if (byte_cnt_q == 3'd7) begin
            resp_valid_d = 1'b1;
            resp_data_d  = lane_d;
            resp_last_d  = (beat_cnt_q == len_q);
            resp_err_d   = 1'b0;
            beat_cnt_d   = beat_cnt_q + LEN_W'(1);
            if (beat_cnt_q == len_q) state_d = S_DONE;
          end
        end else begin
          tmo_d = tmo_q + 16'd1;
          if (tmo_d == TMO_W'(TIMEOUT)) state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        // Bus released; emit the error beat once the holding register is empty
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_last_d  = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_valid_q && resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_last  = resp_last_q;
  assign resp_err   = resp_err_q;
  assign siwu_n     = 1'b1;

endmodule

// File: tb/tb_ft_rd_engine.sv
// tb_ft_rd_engine: directed + randomized bench for ft_rd_engine with an
// FT232H device model and a byte-stream reference for command and beats.
module tb_ft_rd_engine;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned TMO    = 16;
  localparam int          BUDGET = 800;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_data;
  logic              resp_last;
  logic              resp_err;
  logic [7:0]        adbus_i;
  logic [7:0]        adbus_o;
  logic              adbus_oe;
  logic              txe_n;
  logic              rxf_n;
  logic              wr_n;
  logic              rd_n;
  logic              oe_n;
  logic              siwu_n;

  int checks = 0;
  int errors = 0;

  // Per-transaction stimulus knobs
  bit txe_toggle;
  bit rand_ready;
  bit seq_data;
  int gap_after;
  int gap_len;
  int stop_after;
  int hold_beat;
  int hold_len;
  int rst_at;

  ft_rd_engine #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .resp_err   (resp_err),
    .adbus_i    (adbus_i),
    .adbus_o    (adbus_o),
    .adbus_oe   (adbus_oe),
    .txe_n      (txe_n),
    .rxf_n      (rxf_n),
    .wr_n       (wr_n),
    .rd_n       (rd_n),
    .oe_n       (oe_n),
    .siwu_n     (siwu_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ctl"}, 64'({wr_n, rd_n, oe_n, adbus_oe, siwu_n}), 64'(5'b11101));
    chk({tag, "_bus"}, 64'(adbus_o), 64'(0));
    chk({tag, "_resp"}, 64'({resp_valid, resp_last, resp_err}), 64'(0));
    chk({tag, "_data"}, resp_data, 64'(0));
    chk({tag, "_ready"}, 64'(req_ready), 64'(1));
  endtask

  task automatic defaults();
    txe_toggle = 1'b0;
    rand_ready = 1'b0;
    seq_data   = 1'b0;
    gap_after  = -1;
    gap_len    = 0;
    stop_after = -1;
    hold_beat  = -1;
    hold_len   = 0;
    rst_at     = -1;
  endtask

  // One burst: issue request, act as FT232H and consumer, check everything
  task automatic run_txn(input logic [31:0] addr, input logic [LEN_W-1:0] len);
    logic [7:0]  rx_all[$];
    logic [7:0]  cmd_got[$];
    logic [7:0]  cmd_exp[6];
    logic [63:0] exp_data;
    logic [63:0] held_data;
    int total, ncap, beats, idle, cyc, gap_left, hold_left;
    bit done, held, turn_pend, expect_err;

    total = 8 * (int'(len) + 1);
    for (int i = 0; i < total; i++)
      rx_all.push_back(seq_data ? 8'(i + 1) : 8'($urandom));
    expect_err = (stop_after >= 0) && (stop_after < total);
    cmd_exp[0] = 8'h52;
    cmd_exp[1] = 8'(len);
    cmd_exp[2] = addr[7:0];
    cmd_exp[3] = addr[15:8];
    cmd_exp[4] = addr[23:16];
    cmd_exp[5] = addr[31:24];
    ncap = 0; beats = 0; idle = 0; cyc = 0;
    gap_left = gap_len; hold_left = hold_len;
    done = 1'b0; held = 1'b0; turn_pend = 1'b0;
    held_data = '0;

    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_len    = len;
    txe_n      = 1'b0;
    rxf_n      = 1'b1;
    resp_ready = 1'b1;
    #1;
    chk("req_ready_idle", 64'(req_ready), 64'(1));

    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      req_valid = 1'b0;
      txe_n = txe_toggle ? ~txe_n : 1'b0;
      if (stop_after >= 0 && ncap >= stop_after) rxf_n = 1'b1;
      else if (ncap == gap_after && gap_left > 0) begin
        rxf_n = 1'b1;
        gap_left--;
      end else rxf_n = (ncap >= total);
      adbus_i = (ncap < total) ? rx_all[ncap] : 8'h00;
      if (resp_valid && beats == hold_beat && hold_left > 0) begin
        resp_ready = 1'b0;
        hold_left--;
      end else resp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;

      if (cyc == 0) chk("req_ready_busy", 64'(req_ready), 64'(0));

      if (rst_at >= 0) chk("no_beat_before_rst", 64'(resp_valid), 64'(0));
      if (rst_at >= 0 && ncap == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset_state("rst_mid");
        repeat (2) begin
          @(negedge clk);
          #1;
          chk("rst_no_valid", 64'(resp_valid), 64'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_state("rst_release");
        return;
      end

      if (turn_pend) begin
        chk("turn_cycle", 64'({adbus_oe, oe_n, rd_n}), 64'(3'b001));
        turn_pend = 1'b0;
      end
      if (adbus_oe) chk("wr_follows_txe", 64'(wr_n), 64'(txe_n));
      if (!wr_n) begin
        cmd_got.push_back(adbus_o);
        if (cmd_got.size() == 6) turn_pend = 1'b1;
      end
      if (!oe_n) chk("bus_released", 64'(adbus_oe), 64'(0));
      if (!oe_n && resp_valid && !resp_ready && (ncap % 8) == 7)
        chk("stall_rd_high", 64'(rd_n), 64'(1));
      if (held) begin
        chk("hold_valid", 64'(resp_valid), 64'(1));
        chk("hold_data", resp_data, held_data);
      end
      held      = resp_valid && !resp_ready;
      held_data = resp_data;

      if (!rd_n) begin
        chk("rd_needs_rxf", 64'(rxf_n), 64'(0));
        chk("rd_needs_oe", 64'(oe_n), 64'(0));
        ncap++;
        idle = 0;
      end else if (!oe_n && ncap > 0) idle++;

      if (resp_valid && resp_ready) begin
        chk("req_ready_hs", 64'(req_ready), 64'(0));
        if (expect_err) begin
          chk("abort_data", resp_data, 64'(0));
          chk("abort_err", 64'(resp_err), 64'(1));
          chk("abort_last", 64'(resp_last), 64'(1));
          chk("abort_idle", 64'(idle), 64'(TMO));
          done = 1'b1;
        end else begin
          for (int j = 0; j < 8; j++) exp_data[8*j +: 8] = rx_all[8*beats + j];
          chk("beat_data", resp_data, exp_data);
          chk("beat_err", 64'(resp_err), 64'(0));
          chk("beat_last", 64'(resp_last), 64'(beats == int'(len)));
          beats++;
          if (beats == int'(len) + 1) done = 1'b1;
        end
      end
      cyc++;
    end

    chk("txn_done", 64'(done), 64'(1));
    chk("cmd_count", 64'(cmd_got.size()), 64'(6));
    for (int i = 0; i < 6 && i < cmd_got.size(); i++)
      chk("cmd_byte", 64'(cmd_got[i]), 64'(cmd_exp[i]));
    if (!expect_err) chk("beat_count", 64'(beats), 64'(int'(len) + 1));
    @(negedge clk);
    resp_ready = 1'b1;
    rxf_n      = 1'b1;
    #1;
    chk("req_ready_back", 64'(req_ready), 64'(1));
  endtask

  initial begin
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_len    = '0;
    resp_ready = 1'b1;
    adbus_i    = 8'h00;
    txe_n      = 1'b1;
    rxf_n      = 1'b1;
    defaults();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_reset_state("post_reset");

    // Basic single-beat read with bytes 01..08
    seq_data = 1'b1;
    run_txn(32'h0000_1000, 3'd0);
    defaults();

    // TX FIFO back-pressure toggling during the command
    txe_toggle = 1'b1;
    run_txn($urandom, 3'd1);
    defaults();

    // Consumer stalls beat 0 of a 4-beat burst
    hold_beat = 0;
    hold_len  = 12;
    run_txn($urandom, 3'd3);
    defaults();

    // RX FIFO empty for 10 cycles mid-beat
    gap_after = 4;
    gap_len   = 10;
    run_txn($urandom, 3'd0);
    defaults();

    // Device stops after 3 bytes: timeout abort beat
    stop_after = 3;
    run_txn($urandom, 3'd0);
    defaults();

    // Reset in the middle of RD, then a normal burst
    rst_at = 5;
    run_txn($urandom, 3'd0);
    defaults();
    run_txn($urandom, 3'd1);

    // Randomized bursts with random back-pressure
    for (int t = 0; t < 8; t++) begin
      defaults();
      txe_toggle = 1'($urandom_range(0, 1));
      rand_ready = 1'b1;
      run_txn($urandom, 3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
